// File: rtl/dm_responder.sv
// dm_responder: single-port data memory responder, 3072 x 32-bit words
// (byte addresses 0x0000..0x2FFF), request/response handshake, byte-enable writes.
// Optional feature: define DM_WAIT_EN to insert two WAIT cycles between
// accept and response. The default build (DM_WAIT_EN undefined) goes straight
// from IDLE to RESP.
// Writes commit and read data is captured at the accept edge in both builds.
module dm_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int DEPTH = 3072;
    localparam logic [31:0] LAST_ADDR = 32'h0000_2FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        addr_err;
    logic        wr_commit;
    logic [11:0] idx;
    logic [31:0] merged;

`ifdef DM_WAIT_EN
    logic        wait_cnt;
`endif

    // Replace only the enabled byte lanes of the old word with write data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign accept    = (state == IDLE) && req_valid;
    assign addr_err  = (req_addr > LAST_ADDR) || (req_addr[1:0] != 2'b00);
    assign idx       = req_addr[13:2];
    assign wr_commit = accept && req_we && !addr_err;
    assign merged    = merge_bytes(mem[idx], req_wdata, req_be);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    // Response registers keep stale data after a handshake, so gate them.
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;

    // State register; reset wins over any accept at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef DM_WAIT_EN
    // Counts the two WAIT cycles; zero on entry to WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 1'b0;
        end else if (state == WAIT) begin
            wait_cnt <= ~wait_cnt;
        end else begin
            wait_cnt <= 1'b0;
        end
    end
`endif

    // Next-state logic for the IDLE -> (WAIT) -> RESP -> IDLE handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef DM_WAIT_EN
                    state_next = WAIT;
`else
                    state_next = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef DM_WAIT_EN
                if (wait_cnt) begin
                    state_next = RESP;
                end
`else
                state_next = IDLE;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory and response registers; read captures the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= addr_err;
            rdata_q <= (addr_err || req_we) ? 32'h0 : mem[idx];
            if (wr_commit) begin
                mem[idx] <= merged;
            end
        end
    end

`ifndef SYNTHESIS
    // Write log: one line per committed write with the merged word.
    always @(posedge clk) begin
        if (!reset && wr_commit) begin
            $display("@%08h: *%08h <= %08h", req_pc, {req_addr[31:2], 2'b00}, merged);
        end
    end
`endif

endmodule
